// File: rtl/tiny8_types_pkg.sv
// Shared tiny8 word type plus the arbiter state and port enums.
package tiny8_types;

    typedef logic [7:0] tiny8_word;

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_D
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: picks which master wins the memory port; macro TINY8_ARB_RR_EN selects round-robin ties.
// Latency: purely combinational.
// Backpressure: none here; a lone requester always wins, the FSM holds the grant.
module mem_arb_pick
    import tiny8_types::*;
(
    input  logic      if_req,
    input  logic      d_req,
    input  arb_port_t last_grant,
    output arb_port_t winner
);

`ifdef TINY8_ARB_RR_EN
    always_comb begin
        winner = PORT_IF;
        if (d_req && !if_req) begin
            winner = PORT_D;
        end else if (d_req && if_req) begin
            // Tie goes to whichever port was not served last.
            winner = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == PORT_D);

    always_comb begin
        winner = PORT_IF;
        if (d_req) begin
            winner = PORT_D;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: serializes fetch and data accesses onto one memory port (TINY8_ARB_RR_EN: round-robin ties).
// Latency: request seen in IDLE is strobed and answered the next cycle; one access per 2 cycles.
// Backpressure: masters hold requests until resp; a dropped request ends the grant with no resp.
module mem_arbiter
    import tiny8_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      if_read,
    input  tiny8_word if_addr,
    output logic      if_resp,
    output tiny8_word if_rdata,
    input  logic      d_read,
    input  logic      d_write,
    input  tiny8_word d_addr,
    input  tiny8_word d_wdata,
    output logic      d_resp,
    output tiny8_word d_rdata,
    output logic      mem_read,
    output logic      mem_write,
    output tiny8_word mem_addr,
    output tiny8_word mem_wdata,
    input  logic      mem_resp,
    input  tiny8_word mem_rdata
);

    arb_state_t state;
    arb_port_t  last_grant;
    arb_port_t  winner;
    logic       if_req;
    logic       d_req;

    assign if_req = if_read;
    assign d_req  = d_read | d_write;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state <= (winner == PORT_D) ? GNT_D : GNT_IF;
                    end
                end
                GNT_IF: if (!if_req || mem_resp) state <= IDLE;
                GNT_D:  if (!d_req || mem_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TINY8_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_IF;
        end else if (state == GNT_IF && if_req && mem_resp) begin
            last_grant <= PORT_IF;
        end else if (state == GNT_D && d_req && mem_resp) begin
            last_grant <= PORT_D;
        end
    end
`else
    assign last_grant = PORT_IF;
`endif

    always_comb begin
        if_resp   = 1'b0;
        if_rdata  = '0;
        d_resp    = 1'b0;
        d_rdata   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            GNT_IF: begin
                if (if_req) begin
                    mem_read = 1'b1;
                    mem_addr = if_addr;
                    if_resp  = mem_resp;
                    if_rdata = mem_rdata;
                end
            end
            GNT_D: begin
                mem_wdata = d_wdata;
                if (d_req) begin
                    // A simultaneous read+write is treated as a write only.
                    mem_write = d_write;
                    mem_read  = ~d_write;
                    mem_addr  = d_addr;
                    d_resp    = mem_resp;
                    d_rdata   = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: combinational memory model, transaction-level reference, directed and random traffic.
module tb_mem_arbiter;
    import tiny8_types::*;

    logic      clk;
    logic      rst;
    logic      if_read;
    tiny8_word if_addr;
    logic      if_resp;
    tiny8_word if_rdata;
    logic      d_read;
    logic      d_write;
    tiny8_word d_addr;
    tiny8_word d_wdata;
    logic      d_resp;
    tiny8_word d_rdata;
    logic      mem_read;
    logic      mem_write;
    tiny8_word mem_addr;
    tiny8_word mem_wdata;
    logic      mem_resp;
    tiny8_word mem_rdata;

    tiny8_word mem [256];
    tiny8_word ref_mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: owner 0 = nobody, 1 = fetch, 2 = data; last 0 = fetch, 1 = data.
    int owner = 0;
    int last  = 0;
    bit model_valid = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_read   (if_read),
        .if_addr   (if_addr),
        .if_resp   (if_resp),
        .if_rdata  (if_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_resp    (d_resp),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_resp  = mem_read | mem_write;
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic dreq;
        dreq = d_read | d_write;
        if (rst) begin
            if (owner == 2 && dreq && d_write) ref_mem[d_addr] = d_wdata;
            owner = 0;
            last = 0;
            model_valid = 1;
        end else if (owner == 0) begin
            if (if_read && dreq) begin
`ifdef TINY8_ARB_RR_EN
                owner = (last == 0) ? 2 : 1;
`else
                owner = 2;
`endif
            end else if (dreq) begin
                owner = 2;
            end else if (if_read) begin
                owner = 1;
            end
        end else begin
            if (owner == 1 && if_read) last = 0;
            if (owner == 2 && dreq) begin
                last = 1;
                if (d_write) ref_mem[d_addr] = d_wdata;
            end
            owner = 0;
        end
    end

    always @(negedge clk) begin
        logic dreq, e_rd, e_wr, e_ir, e_dr;
        if (model_valid) begin
            dreq = d_read | d_write;
            e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0;
            if (owner == 1 && if_read) begin
                e_rd = 1; e_ir = 1;
            end
            if (owner == 2 && dreq) begin
                e_wr = d_write; e_rd = !d_write; e_dr = 1;
            end
            chk("m_mem_read", 8'(mem_read), 8'(e_rd));
            chk("m_mem_write", 8'(mem_write), 8'(e_wr));
            chk("m_if_resp", 8'(if_resp), 8'(e_ir));
            chk("m_d_resp", 8'(d_resp), 8'(e_dr));
            if (e_ir) begin
                chk("m_if_addr", mem_addr, if_addr);
                chk("m_if_rdata", if_rdata, ref_mem[if_addr]);
            end
            if (owner != 1) chk("m_if_rdata_idle", if_rdata, 8'h00);
            if (e_dr) chk("m_d_addr", mem_addr, d_addr);
            if (e_dr && !d_write) chk("m_d_rdata", d_rdata, ref_mem[d_addr]);
            if (e_wr) chk("m_wdata", mem_wdata, d_wdata);
            if (owner != 2) begin
                chk("m_d_rdata_idle", d_rdata, 8'h00);
                chk("m_wdata_idle", mem_wdata, 8'h00);
            end
            if (owner == 0) chk("m_addr_idle", mem_addr, 8'h00);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic s_if, s_d;
        int kind;
        rst = 1; if_read = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            tiny8_word v;
            v = tiny8_word'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[3] = 8'h5A;
        ref_mem[3] = 8'h5A;

        nxt();
        @(negedge clk);
        chk("rst_mem_read", 8'(mem_read), 8'h00);
        chk("rst_mem_write", 8'(mem_write), 8'h00);
        chk("rst_if_resp", 8'(if_resp), 8'h00);
        chk("rst_d_resp", 8'(d_resp), 8'h00);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_if_rdata", if_rdata, 8'h00);
        chk("rst_d_rdata", d_rdata, 8'h00);
        nxt();
        rst = 0;

        // Fetch read of mem[3].
        if_read = 1; if_addr = 8'd3;
        @(negedge clk);
        chk("fetch_idle_read", 8'(mem_read), 8'h00);
        nxt();
        @(negedge clk);
        chk("fetch_mem_read", 8'(mem_read), 8'h01);
        chk("fetch_resp", 8'(if_resp), 8'h01);
        chk("fetch_rdata", if_rdata, 8'h5A);
        chk("fetch_d_resp", 8'(d_resp), 8'h00);
        chk("fetch_addr", mem_addr, 8'h03);
        nxt();
        if_read = 0;

        // Write then read back mem[6].
        d_write = 1; d_addr = 8'd6; d_wdata = 8'hC3;
        nxt();
        @(negedge clk);
        chk("wr_mem_write", 8'(mem_write), 8'h01);
        chk("wr_mem_read", 8'(mem_read), 8'h00);
        chk("wr_resp", 8'(d_resp), 8'h01);
        chk("wr_wdata", mem_wdata, 8'hC3);
        nxt();
        d_write = 0; d_read = 1;
        nxt();
        @(negedge clk);
        chk("rd_resp", 8'(d_resp), 8'h01);
        chk("rd_rdata", d_rdata, 8'hC3);
        nxt();
        d_read = 0;

        // Read and write together act as a write.
        d_read = 1; d_write = 1; d_addr = 8'd1; d_wdata = 8'h11;
        nxt();
        @(negedge clk);
        chk("both_mem_write", 8'(mem_write), 8'h01);
        chk("both_mem_read", 8'(mem_read), 8'h00);
        nxt();
        d_read = 0; d_write = 0;
        @(negedge clk);
        chk("both_mem1", mem[1], 8'h11);

        // Reset pulsed while fetch is granted.
        nxt();
        if_read = 1; if_addr = 8'd3;
        nxt();
        rst = 1;
        @(negedge clk);
        chk("rstmid_granted", 8'(if_resp), 8'h01);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("rstmid_mem_read", 8'(mem_read), 8'h00);
        chk("rstmid_if_resp", 8'(if_resp), 8'h00);
        chk("rstmid_addr", mem_addr, 8'h00);
        chk("rstmid_if_rdata", if_rdata, 8'h00);
        nxt();
        @(negedge clk);
        chk("rstmid_regrant", 8'(if_resp), 8'h01);
        nxt();
        if_read = 0;

        // Fetch drops its request while granted; pending data read follows.
        nxt();
        if_read = 1; if_addr = 8'd3;
        nxt();
        if_read = 0; d_read = 1; d_addr = 8'd6;
        @(negedge clk);
        chk("drop_if_resp", 8'(if_resp), 8'h00);
        chk("drop_mem_read", 8'(mem_read), 8'h00);
        nxt();
        @(negedge clk);
        chk("drop_idle_d_resp", 8'(d_resp), 8'h00);
        nxt();
        @(negedge clk);
        chk("drop_d_resp", 8'(d_resp), 8'h01);
        chk("drop_d_rdata", d_rdata, 8'hC3);
        nxt();
        d_read = 0;

        // Both masters requesting continuously from reset.
        rst = 1;
        nxt();
        rst = 0;
        if_read = 1; if_addr = 8'd3; d_read = 1; d_addr = 8'd6;
        for (int k = 0; k < 8; k++) begin
            logic ei, ed;
            @(negedge clk);
            ei = 0; ed = 0;
`ifdef TINY8_ARB_RR_EN
            if (k % 4 == 1) ed = 1;
            if (k % 4 == 3) ei = 1;
`else
            if (k % 2 == 1) ed = 1;
`endif
            chk("tie_if_resp", 8'(if_resp), 8'(ei));
            chk("tie_d_resp", 8'(d_resp), 8'(ed));
            nxt();
        end
        if_read = 0; d_read = 0;
        nxt();

        // Random traffic with occasional drops and resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s_if = if_resp;
            s_d = d_resp;
            nxt();
            if (if_read) begin
                if (s_if || $urandom_range(15) == 0) if_read = 0;
            end else if ($urandom_range(2) == 0) begin
                if_read = 1;
                if_addr = tiny8_word'($urandom);
            end
            if (d_read || d_write) begin
                if (s_d || $urandom_range(15) == 0) begin
                    d_read = 0;
                    d_write = 0;
                end
            end else if ($urandom_range(2) == 0) begin
                kind = $urandom_range(3);
                d_read = (kind == 0 || kind == 2);
                d_write = (kind == 1 || kind == 2 || kind == 3);
                d_addr = tiny8_word'($urandom_range(15));
                d_wdata = tiny8_word'($urandom);
            end
            rst = ($urandom_range(99) == 0);
        end
        rst = 0; if_read = 0; d_read = 0; d_write = 0;
        nxt();
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter directly upstream of the tiny8 memory: it serializes instruction-fetch reads and datapath loads/stores onto the single `read`/`write`/`addr`/`wdata` port of `memory`. It returns `resp`/`rdata` to whichever master holds the grant. A registered grant FSM keeps every memory access aligned to a clean cycle boundary, even though the memory itself responds combinationally.

## Interface
- No parameters; widths come from `tiny8_types::tiny8_word` (8 bits).
- `clk` in 1: sole clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `if_read` in 1: fetch read request; held until `if_resp`.
- `if_addr` in tiny8_word: fetch address.
- `if_resp` out 1: fetch access complete this cycle.
- `if_rdata` out tiny8_word: fetch read data, valid when `if_resp`.
- `d_read` in 1: data read request; held until `d_resp`.
- `d_write` in 1: data write request; held until `d_resp`.
- `d_addr` in tiny8_word: data address.
- `d_wdata` in tiny8_word: data write value.
- `d_resp` out 1: data access complete this cycle.
- `d_rdata` out tiny8_word: data read data, valid when `d_resp`.
- `mem_read` out 1: to memory `read`.
- `mem_write` out 1: to memory `write`.
- `mem_addr` out tiny8_word: to memory `addr`.
- `mem_wdata` out tiny8_word: to memory `wdata`.
- `mem_resp` in 1: from memory `resp`.
- `mem_rdata` in tiny8_word: from memory `rdata`.

## Operation
- States: `IDLE`, `GNT_IF`, `GNT_D`.
- IDLE:
  - Drive no memory strobes.
  - If any request is pending, select a winner and move to the matching GNT state on the next edge.
  - With no request pending, stay in IDLE.
- GNT_IF:
  - Drive `mem_read=1` and `mem_addr=if_addr`.
  - `if_resp=mem_resp`; `if_rdata=mem_rdata`.
  - On `mem_resp`, return to IDLE and record the fetch port as the last grant.
- GNT_D:
  - Drive `mem_addr=d_addr` and `mem_wdata=d_wdata`.
  - If `d_write`, drive `mem_write=1`; otherwise drive `mem_read=1`.
  - `d_resp=mem_resp`; `d_rdata=mem_rdata`.
  - On `mem_resp`, return to IDLE and record the data port as the last grant.
- `d_read` and `d_write` asserted together: treated as a write; the read is ignored.
- Master drops its request while granted: strobes deassert that cycle, no resp is issued, FSM returns to IDLE.
- The non-granted master never sees resp; its `*_rdata` is driven 0.
- `mem_wdata` is driven 0 outside GNT_D.

## Timing
- Reset values:
  - `if_resp`, `d_resp`, `mem_read`, `mem_write`: 0.
  - `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata`: 0.
  - State = IDLE; last-grant = IF.
- Latency: request seen in IDLE at cycle N → strobe driven and resp returned in cycle N+1 (the memory responds the same cycle).
- Back-to-back throughput: one access per 2 cycles, since each grant always passes through IDLE.
- Strobes and resp are Moore/combinational on the registered state. Addresses and data are passed through combinationally from the granted master.
- `rst` asserted mid-grant: next edge forces IDLE; any in-flight write is still committed only if the memory sampled it on that same edge.

## Configuration
- `TINY8_ARB_RR_EN` defined: round-robin on a tie. The port opposite to last-grant wins, so after reset the first tie goes to data.
- Undefined: fixed priority, data always beats fetch on a tie; last-grant is not implemented.
- A lone requester wins immediately in both modes.

## Structure
- `tiny8_types` gains:
  - `arb_state_t` enum {IDLE, GNT_IF, GNT_D}.
  - `arb_port_t` enum {PORT_IF, PORT_D}.
- One sub-module, `mem_arb_pick`: combinational winner selection from (`if_req`, `d_req`, `last_grant`) producing `arb_port_t`; its RR vs fixed behaviour is selected by the macro.
- The FSM and output muxing stay in `mem_arbiter`.

## Test plan
- Reset, then `if_read` with `if_addr=3` (mem[3]=0x5A) → `mem_read`=1 and `if_resp`=1 with `if_rdata`=0x5A one cycle later; `d_resp` stays 0.
- `d_write` with `d_addr=6`, `d_wdata=0xC3`, then `d_read` with `d_addr=6` → `d_rdata`=0xC3; write issued with `mem_write`=1 and `mem_read`=0.
- Both ports request continuously from reset:
  - RR build: grants alternate D, IF, D, IF with one resp every 2 cycles.
  - Fixed build: only `d_resp` ever fires.
- `d_read` and `d_write` together with `d_addr=1`, `d_wdata=0x11` → only `mem_write` asserted; mem[1]=0x11.
- `rst` pulsed during GNT_IF → next cycle all outputs 0 and state IDLE; a held `if_read` is granted again one cycle after `rst` falls.
- `if_read` dropped while in GNT_IF → no `if_resp`; FSM back to IDLE and a pending `d_read` is granted next.
